// File: rtl/ifetch_pkg.sv
// Purpose: shared constants, FSM encodings and the fetch entry layout for the instruction-fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

    // Value presented on instr_o when nothing is buffered (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch FSM encodings, kept as plain constants so older tools accept them.
    typedef logic [1:0] state_t;
    localparam state_t ST_BOOT = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HALT = 2'd2;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Purpose: small synchronous FIFO with flush; head entry is visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the writer must keep occupancy within DEPTH.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Flush dominates both ports; popping an empty FIFO is ignored.
    assign push_ok  = push & ~flush;
    assign pop_ok   = pop & ~flush & (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Purpose: sequential instruction fetch from a 1-cycle BRAM into a prefetch FIFO, with redirect/halt handling.
// Latency: request to decode-visible is 2 cycles; a redirect's target reaches valid_o 3 cycles after the redirect.
// Backpressure: ready_i stalls the FIFO head; issue stops once buffered + in-flight entries reach FIFO_DEPTH.
// Optional build macro IFETCH_MISALIGN_CHK_EN: flags misaligned redirect targets and parks the fetcher until the next redirect.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] imem_pc_o,
    output logic        imem_enb_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        misalign_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   inflight_pc_q;
    logic          inflight_q;
    logic          issue;
    logic          push;
    logic          pop;
    logic          redir_live;
    logic          mis_redirect;
    logic          mis_hold;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Slots already committed: buffered entries plus the response still on its way.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue      = (state_q == ST_RUN) & ~redirect_i & (occupancy < DEPTH_V);
    assign imem_enb_o = issue;
    assign imem_pc_o  = fetch_pc_q;

    // A redirect kills the response landing this cycle; the BRAM output is
    // only meaningful in the cycle right after an issue.
    assign push       = inflight_q & ~redirect_i;
    assign push_entry = '{pc: inflight_pc_q, instr: imem_instr_i};
    assign pop        = valid_o & ready_i;
    assign redir_live = redirect_i & (state_q != ST_BOOT);

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect_i),
        .head_dat (head),
        .count    (fifo_count)
    );

    assign valid_o = (fifo_count != '0);
    assign instr_o = valid_o ? head.instr : NOP_INSTR;
    assign pc_o    = valid_o ? head.pc    : 32'h0000_0000;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q;
    logic mis_hold_q;

    assign mis_redirect = redir_live & (redirect_pc_i[1:0] != 2'b00);
    assign mis_hold     = mis_hold_q;
    assign misalign_o   = misalign_q;

    // One-cycle misalign pulse, plus a sticky park flag cleared by the next accepted redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
            mis_hold_q <= 1'b0;
        end else begin
            misalign_q <= mis_redirect;
            if (redir_live) begin
                mis_hold_q <= mis_redirect;
            end
        end
    end
`else
    logic unused_pc_lsbs;

    // Low target bits are simply dropped when the check is compiled out.
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign mis_redirect   = 1'b0;
    assign mis_hold       = 1'b0;
    assign misalign_o     = 1'b0;
`endif

    // Next-state logic: boot lasts one cycle, halt_i toggles RUN/HALT, redirects restart fetch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_i) state_d = ST_HALT;
            ST_HALT: if (!halt_i && !mis_hold) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
        if (redir_live) begin
            state_d = (halt_i || mis_redirect) ? ST_HALT : ST_RUN;
        end
    end

    // FSM state, fetch address and the single outstanding-request tracker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
            end
            if (redirect_i) begin
                fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

endmodule
